// File: rtl/branch_predictor.sv
// Direct-mapped direction/target predictor: zero-latency lookup at IF, trained from EX on the next clk edge.
// No backpressure: one lookup and at most one update every cycle; mispredict and redirect_pc are combinational.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             upd;
    logic             ex_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Gating with rst_n keeps every output at its reset value while reset is held.
    assign pred_hit    = rst_n && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = pred_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

    assign upd         = ex_valid && ex_is_branch;
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign mispredict  = rst_n && upd &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = (rst_n && ex_taken) ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (upd) begin
                if (branch_cnt != 32'hFFFF_FFFF) begin
                    branch_cnt <= branch_cnt + 32'd1;
                end
                if (ex_hit) begin
                    if (ex_taken && ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end else if (!ex_taken && ctr_q[ex_idx] != 2'b00) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                    end
                end else if (ex_taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    ctr_q[ex_idx]   <= 2'b10;
                end
            end
            if (mispredict && mispred_cnt != 32'hFFFF_FFFF) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    // Tag/target need no reset; a taken update either refreshes a hit or allocates a miss.
    always_ff @(posedge clk) begin
        if (rst_n && upd && ex_taken) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed stimulus for branch_predictor, checked against a table-level reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_bcnt;
    longint      m_mcnt;

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && m_tag[midx(pc)] == mtag(pc);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && m_ctr[midx(pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Drive one cycle of inputs, check all outputs against the model, then advance past the edge.
    task automatic step(input logic [31:0] pc, input bit ev, input bit eb, input logic [31:0] epc,
                        input bit et, input logic [31:0] etgt, input bit ept, input logic [31:0] eptg);
        bit          u;
        bit          mp;
        int          i;
        if_pc = pc; ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
        ex_taken = et; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptg;
        #2;
        u  = ev && eb;
        mp = u && (et != ept || (et && eptg != etgt));
        check("pred_hit",    {31'd0, pred_hit},   {31'd0, m_hit(pc)});
        check("pred_taken",  {31'd0, pred_taken}, {31'd0, m_taken(pc)});
        check("pred_target", pred_target, m_target(pc));
        check("mispredict",  {31'd0, mispredict}, {31'd0, mp});
        check("redirect_pc", redirect_pc, et ? etgt : epc + 32'd4);
        check("branch_cnt",  branch_cnt,  sat32(m_bcnt));
        check("mispred_cnt", mispred_cnt, sat32(m_mcnt));
        if (u) begin
            i = midx(epc);
            m_bcnt++;
            if (mp) m_mcnt++;
            if (m_hit(epc)) begin
                if (et) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = etgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (et) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = mtag(epc);
                m_tgt[i]   = etgt;
                m_ctr[i]   = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic rand_steps(input int n);
        logic [31:0] pc, epc, etgt, eptg;
        bit          ept;
        for (int k = 0; k < n; k++) begin
            pc   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            epc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            etgt = {20'd0, 10'($urandom_range(0, 7) * 64), 2'b00};
            if ($urandom_range(0, 3) != 0) begin
                ept  = m_taken(epc);
                eptg = m_target(epc);
            end else begin
                ept  = 1'($urandom);
                eptg = {20'd0, 10'($urandom_range(0, 7) * 64), 2'b00};
            end
            step(pc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0), epc,
                 1'($urandom), etgt, ept, eptg);
        end
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        if_pc = 32'h40; ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h40;
        ex_taken = 1'b1; ex_target = 32'h100; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        #3;
        check("rst_pred_hit",    {31'd0, pred_hit},   32'd0);
        check("rst_pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h44);
        check("rst_mispredict",  {31'd0, mispredict}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'h44);
        check("rst_branch_cnt",  branch_cnt,  32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_cnt", branch_cnt, 32'd0);
        rst_n = 1'b1;

        // Directed walk through the main scenarios.
        lookup(32'h40);
        check("dir_miss_target", pred_target, 32'h44);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100);
        check("dir_alloc_cnt", branch_cnt, 32'd2);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100);
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 1, 32'h100);
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 1, 32'h100);
        check("dir_hyst_target", pred_target, 32'h44);
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 0, 32'h44);
        step(32'h40, 1, 1, 32'h40, 1, 32'h180, 1, 32'h100);
        step(32'h40, 1, 1, 32'h40, 1, 32'h180, 0, 32'h44);
        lookup(32'h40);
        check("dir_new_target", pred_target, 32'h180);
        step(32'h40, 1, 1, 32'h80, 1, 32'h200, 0, 32'h84);
        lookup(32'h40);
        step(32'h80, 1, 1, 32'hC0, 0, 32'h300, 0, 32'hC4);
        check("dir_alias_target", pred_target, 32'h200);
        lookup(32'h80);
        step(32'h80, 1, 1, 32'h80, 0, 32'h200, 1, 32'h200);
        lookup(32'h80);
        step(32'h80, 0, 1, 32'h80, 1, 32'h200, 0, 32'h84);
        step(32'h80, 1, 0, 32'h80, 1, 32'h200, 0, 32'h84);
        lookup(32'hFFFF_FFFC);
        step(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);

        rand_steps(1500);

        // Reset asserted between edges must clear everything at once.
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        if_pc = 32'h40;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("mid_rst_pred_hit",    {31'd0, pred_hit}, 32'd0);
        check("mid_rst_pred_target", pred_target, 32'h44);
        check("mid_rst_branch_cnt",  branch_cnt,  32'd0);
        check("mid_rst_mispred_cnt", mispred_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rand_steps(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direction and target predictor for the RISC-V pipeline.
- It is the consumer side of the execute-stage branch compare. It predicts at IF, then takes the resolved taken/not-taken result and actual target from EX to train itself.
- It also flags a misprediction and supplies the redirect PC, and keeps performance counters.
- Storage is a direct-mapped table of entries. Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.

Parameters:
- ENTRIES, 16, number of table entries; must be a power of 2, minimum 4.
- IDX_W, 4, log2(ENTRIES).
- TAG_W, 26, equal to 32-IDX_W-2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  32  PC being fetched.
- pred_hit  output  1  table hit for if_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  32  predicted next PC.
- ex_valid  input  1  EX-stage instruction valid (not bubble/flushed).
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  32  PC of the EX branch.
- ex_taken  input  1  resolved outcome from branch compare.
- ex_target  input  32  computed branch target (ex_pc+imm).
- ex_pred_taken  input  1  pred_taken carried down the pipeline with this instruction.
- ex_pred_target  input  32  pred_target carried down the pipeline.
- mispredict  output  1  flush IF/ID, redirect fetch.
- redirect_pc  output  32  correct next PC.
- branch_cnt  output  32  resolved branch count.
- mispred_cnt  output  32  mispredict count.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Reset, asynchronous on rst_n low:
  - all valid=0, all counters=2'b01 (weakly not-taken); tags and targets are don't-care;
  - branch_cnt=0, mispred_cnt=0.
- Outputs while reset is asserted: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=ex_pc+4.
- Prediction (combinational from if_pc and current table state, zero latency):
  - pred_hit = valid[idx] && tag[idx]==if_tag;
  - pred_taken = pred_hit && ctr[idx][1];
  - pred_target = pred_taken ? target[idx] : if_pc+4 (mod 2^32).
- Resolution (combinational):
  - upd = ex_valid && ex_is_branch;
  - mispredict = upd && (ex_taken!=ex_pred_taken || (ex_taken && ex_pred_target!=ex_target));
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, always driven but meaningful only when mispredict=1.
- Update, on the rising clk edge when upd=1, using index/tag of ex_pc:
  - Tag hit, ex_taken=1: ctr = min(ctr+1, 3); target = ex_target.
  - Tag hit, ex_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), ex_taken=1: allocate/replace. valid=1, tag=ex tag, target=ex_target, ctr=2'b10.
  - Miss, ex_taken=0: no table change.
- Counters: branch_cnt += 1 on every upd. mispred_cnt += 1 when mispredict. Both saturate at 32'hFFFF_FFFF and do not wrap.
- upd=0 (bubble, non-branch, or ex_valid=0 with ex_is_branch=1): no state change, mispredict=0.
- Same-cycle IF read and EX write to the same index: IF sees pre-update state. There is no bypass; the new value is visible the next cycle.
- Aliasing: a different tag at the same index on a taken branch evicts the old entry. A not-taken branch never evicts.
- Reset mid-operation clears the table and counters immediately, without waiting for clk.
- All arithmetic is 32-bit unsigned modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).

Test Plan:
- Reset, then if_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044; branch_cnt=0.
- One upd with ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0 -> mispredict=1 and redirect_pc=0x100 that cycle. Next cycle with if_pc=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x100. Counters: branch_cnt=1, mispred_cnt=1.
- Saturation and hysteresis: from ctr=10, two taken updates give 11. One not-taken update then gives 10, so the branch is still predicted taken. A second not-taken gives 01, predicted not-taken, with pred_target=0x44. Checking ex_pred_taken=0 with ex_taken=0 gives mispredict=0.
- Alias: entry at 0x40 is valid; update ex_pc=0x80 (same index at ENTRIES=16), taken, target 0x200 -> 0x40 now misses and 0x80 hits with target 0x200. A not-taken miss at 0xC0 leaves 0x80's entry intact.
- Target change: hit entry target 0x100, ex_taken=1, ex_pred_taken=1, ex_pred_target=0x100, ex_target=0x180 -> mispredict=1, redirect_pc=0x180, stored target becomes 0x180.
- Same-cycle read/write on the same index shows the old prediction. Asserting rst_n=0 between edges immediately gives pred_hit=0 and both counters 0. Pulsing ex_valid=0 with ex_is_branch=1 leaves the counters unchanged.
